// File: rtl/ram_latency_responder_pkg.sv
// Shared types and helpers for the latency-injecting RAM responder.
// Word width, FSM state encoding and byte-to-word address mapping.
package ram_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } ram_state_t;

    function automatic logic [31:0] word_index(
        input logic [31:0] addr,
        input int unsigned depth
    );
        return (addr >> 2) & (depth - 1);
    endfunction

endpackage

// File: rtl/ram_latency_responder_if.sv
// Word-level RAM request/response bundle between block glue and memory.
// The master issues requests; the slave stalls with ram_miss and answers.
interface ram_latency_responder_if;

    logic        ram_req;
    logic [31:0] ram_addr;
    logic        ram_we;
    logic [31:0] ram_write_word;
    logic [31:0] ram_read_word;
    logic        ram_miss;

    modport master (
        output ram_req,
        output ram_addr,
        output ram_we,
        output ram_write_word,
        input  ram_read_word,
        input  ram_miss
    );

    modport slave (
        input  ram_req,
        input  ram_addr,
        input  ram_we,
        input  ram_write_word,
        output ram_read_word,
        output ram_miss
    );

endinterface

// File: rtl/ram_latency_responder_word_array.sv
// DEPTH x 32 storage with a per-word written flag.
// Flags clear asynchronously so reset makes every word read as unwritten.
module ram_word_array
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [WORD_W-1:0]        rd_data,
    output logic                     rd_written
);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;

    // Storage itself is never reset; the written flags decide validity.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Mark a word valid once it has been written.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            written <= '0;
        end else if (wr_en) begin
            written[wr_idx] <= 1'b1;
        end
    end

    // Combinational read port.
    always_comb begin
        rd_data    = mem[rd_idx];
        rd_written = written[rd_idx];
    end

endmodule

// File: rtl/ram_latency_responder.sv
// RAM responder that stalls each word access for LATENCY cycles.
// Unwritten words echo their own byte address on reads.
module ram_latency_responder
    import ram_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned LATENCY = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    ram_latency_responder_if.slave  bus,
    output logic                    protocol_err
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam bit ZERO_LAT = (LATENCY == 0);

    ram_state_t        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [29:0]       addr_q;
    logic              we_q;

    logic [31:0]       cur_byte;
    logic [31:0]       echo;
    logic              cur_we;
    logic              complete;
    logic              mismatch;
    logic [IDX_W-1:0]  idx;
    logic              wr_en;
    logic [WORD_W-1:0] rd_data;
    logic              rd_written;

    // Completion decode, stall output and read data mux.
    always_comb begin
        cur_byte = ZERO_LAT ? bus.ram_addr : {addr_q, 2'b00};
        cur_we   = ZERO_LAT ? bus.ram_we : we_q;
        echo     = {cur_byte[31:2], 2'b00};
        idx      = IDX_W'(word_index(cur_byte, DEPTH));
        complete = reset && bus.ram_req &&
                   (ZERO_LAT ? (state == IDLE) : (state == RESP));
        wr_en    = complete && cur_we;
        bus.ram_miss = bus.ram_req &&
                       (((state == IDLE) && !ZERO_LAT) || (state == WAIT));
        bus.ram_read_word = '0;
        if (complete && !cur_we) begin
            bus.ram_read_word = rd_written ? rd_data : echo;
        end
        mismatch = bus.ram_req &&
                   ((state == WAIT) || (state == RESP)) &&
                   ((bus.ram_addr[31:2] != addr_q) || (bus.ram_we != we_q));
    end

    // Access FSM, wait counter, request latches and sticky error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (mismatch) begin
                protocol_err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (bus.ram_req && !ZERO_LAT) begin
                        addr_q   <= bus.ram_addr[31:2];
                        we_q     <= bus.ram_we;
                        wait_cnt <= CNT_W'(LATENCY - 1);
                        state    <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!bus.ram_req) begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else if (wait_cnt <= CNT_W'(1)) begin
                        wait_cnt <= '0;
                        state    <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    ram_word_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_idx    (idx),
        .wr_data   (bus.ram_write_word),
        .rd_idx    (idx),
        .rd_data   (rd_data),
        .rd_written(rd_written)
    );

endmodule

// File: tb/tb_ram_latency_responder.sv
// Scoreboard bench for ram_latency_responder with LATENCY=2 and LATENCY=0.
// Expected responses come from an array model of the word memory.
module tb_ram_latency_responder;

    localparam int DEPTH = 16;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    ram_latency_responder_if b2 ();
    ram_latency_responder_if b0 ();

    logic perr2;
    logic perr0;

    ram_latency_responder #(
        .DEPTH  (DEPTH),
        .LATENCY(2)
    ) dut2 (
        .clock       (clock),
        .reset       (reset),
        .bus         (b2.slave),
        .protocol_err(perr2)
    );

    ram_latency_responder #(
        .DEPTH  (DEPTH),
        .LATENCY(0)
    ) dut0 (
        .clock       (clock),
        .reset       (reset),
        .bus         (b0.slave),
        .protocol_err(perr0)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q2 [$];
    logic [31:0] exp_q0 [$];
    logic [31:0] mem2 [DEPTH];
    logic [31:0] mem0 [DEPTH];
    bit          wr2 [DEPTH];
    bit          wr0 [DEPTH];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic expect2(input logic [31:0] a, input bit we,
                           input logic [31:0] d);
        int i;
        i = widx(a);
        if (we) begin
            mem2[i] = d;
            wr2[i]  = 1'b1;
            exp_q2.push_back(32'h0);
        end else begin
            exp_q2.push_back(wr2[i] ? mem2[i] : (a & 32'hFFFF_FFFC));
        end
    endtask

    task automatic expect0(input logic [31:0] a, input bit we,
                           input logic [31:0] d);
        int i;
        i = widx(a);
        if (we) begin
            mem0[i] = d;
            wr0[i]  = 1'b1;
            exp_q0.push_back(32'h0);
        end else begin
            exp_q0.push_back(wr0[i] ? mem0[i] : (a & 32'hFFFF_FFFC));
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            wr2[i] = 1'b0;
            wr0[i] = 1'b0;
        end
    endtask

    task automatic access2(input logic [31:0] a, input bit we,
                           input logic [31:0] d, output int cyc);
        @(posedge clock);
        #1;
        b2.ram_req        = 1'b1;
        b2.ram_addr       = a;
        b2.ram_we         = we;
        b2.ram_write_word = d;
        expect2(a, we, d);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (b2.ram_miss && cyc < 20);
        check("latency2", cyc, 3);
    endtask

    task automatic access0(input logic [31:0] a, input bit we,
                           input logic [31:0] d);
        @(posedge clock);
        #1;
        b0.ram_req        = 1'b1;
        b0.ram_addr       = a;
        b0.ram_we         = we;
        b0.ram_write_word = d;
        expect0(a, we, d);
        @(negedge clock);
        check("miss0", {31'h0, b0.ram_miss}, 32'h0);
    endtask

    task automatic idle2();
        @(posedge clock);
        #1;
        b2.ram_req = 1'b0;
    endtask

    task automatic idle0();
        @(posedge clock);
        #1;
        b0.ram_req = 1'b0;
    endtask

    // Pop and compare on every completion; otherwise read data must be 0.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (b2.ram_req && !b2.ram_miss) begin
                if (exp_q2.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp2: got completion %h, expected none",
                             b2.ram_read_word);
                end else begin
                    check("resp2", b2.ram_read_word, exp_q2.pop_front());
                end
            end else begin
                check("quiet2", b2.ram_read_word, 32'h0);
            end
            if (b0.ram_req && !b0.ram_miss) begin
                if (exp_q0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp0: got completion %h, expected none",
                             b0.ram_read_word);
                end else begin
                    check("resp0", b0.ram_read_word, exp_q0.pop_front());
                end
            end else begin
                check("quiet0", b0.ram_read_word, 32'h0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int total;
        logic [31:0] a;
        bit we;

        reset = 1'b0;
        b2.ram_req = 1'b0;
        b2.ram_addr = '0;
        b2.ram_we = 1'b0;
        b2.ram_write_word = '0;
        b0.ram_req = 1'b0;
        b0.ram_addr = '0;
        b0.ram_we = 1'b0;
        b0.ram_write_word = '0;
        clear_model();

        // Reset state.
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_miss2", {31'h0, b2.ram_miss}, 32'h0);
        check("rst_read2", b2.ram_read_word, 32'h0);
        check("rst_perr2", {31'h0, perr2}, 32'h0);
        b2.ram_req = 1'b1;
        b0.ram_req = 1'b1;
        #1;
        check("rst_miss2_req", {31'h0, b2.ram_miss}, 32'h1);
        check("rst_miss0_req", {31'h0, b0.ram_miss}, 32'h0);
        check("rst_read0_req", b0.ram_read_word, 32'h0);
        b2.ram_req = 1'b0;
        b0.ram_req = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Unwritten read echoes its address.
        access2(32'h14, 1'b0, 32'h0, cyc);
        idle2();

        // Write then read back.
        access2(32'h08, 1'b1, 32'hDEAD_BEEF, cyc);
        idle2();
        access2(32'h08, 1'b0, 32'h0, cyc);
        idle2();

        // Alias setup then a back-to-back 4-word burst.
        access2(32'h00, 1'b1, 32'h1234, cyc);
        idle2();
        total = 0;
        for (int k = 0; k < 4; k++) begin
            access2(32'h40 + 32'(4 * k), 1'b0, 32'h0, cyc);
            total += cyc;
        end
        check("burst_cycles", total, 12);
        idle2();

        // Abort a write while waiting.
        @(posedge clock);
        #1;
        b2.ram_req = 1'b1;
        b2.ram_addr = 32'h04;
        b2.ram_we = 1'b1;
        b2.ram_write_word = 32'hCAFE;
        @(negedge clock);
        check("abort_c1_miss", {31'h0, b2.ram_miss}, 32'h1);
        @(posedge clock);
        #1;
        b2.ram_req = 1'b0;
        @(negedge clock);
        check("abort_miss", {31'h0, b2.ram_miss}, 32'h0);
        access2(32'h04, 1'b0, 32'h0, cyc);
        idle2();
        check("abort_perr", {31'h0, perr2}, 32'h0);

        // Address change during the wait.
        @(posedge clock);
        #1;
        b2.ram_req = 1'b1;
        b2.ram_addr = 32'h10;
        b2.ram_we = 1'b0;
        expect2(32'h10, 1'b0, 32'h0);
        @(negedge clock);
        @(posedge clock);
        #1;
        b2.ram_addr = 32'h20;
        @(negedge clock);
        check("perr_before", {31'h0, perr2}, 32'h0);
        @(negedge clock);
        check("perr_compl_miss", {31'h0, b2.ram_miss}, 32'h0);
        check("perr_rise", {31'h0, perr2}, 32'h1);
        idle2();
        repeat (2) @(negedge clock);
        check("perr_sticky", {31'h0, perr2}, 32'h1);

        // Zero-latency instance.
        access0(32'h18, 1'b1, 32'h77);
        access0(32'h18, 1'b0, 32'h0);
        access0(32'h1C, 1'b0, 32'h0);
        access0(32'h58, 1'b0, 32'h0);
        idle0();

        // Reset in the middle of a write.
        @(posedge clock);
        #1;
        b2.ram_req = 1'b1;
        b2.ram_addr = 32'h0C;
        b2.ram_we = 1'b1;
        b2.ram_write_word = 32'h5555;
        @(negedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        b2.ram_req = 1'b0;
        clear_model();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_perr", {31'h0, perr2}, 32'h0);
        access2(32'h0C, 1'b0, 32'h0, cyc);
        access2(32'h08, 1'b0, 32'h0, cyc);
        idle2();
        access0(32'h18, 1'b0, 32'h0);
        idle0();

        // Randomised traffic.
        for (int n = 0; n < 80; n++) begin
            a = $urandom();
            we = 1'($urandom_range(0, 1));
            access2(a, we, $urandom(), cyc);
            if ($urandom_range(0, 3) == 0) idle2();
        end
        idle2();
        for (int n = 0; n < 80; n++) begin
            a = $urandom();
            we = 1'($urandom_range(0, 1));
            access0(a, we, $urandom());
            if ($urandom_range(0, 3) == 0) idle0();
        end
        idle0();
        repeat (3) @(negedge clock);

        check("rand_perr2", {31'h0, perr2}, 32'h0);
        check("rand_perr0", {31'h0, perr0}, 32'h0);
        check("queue2_empty", exp_q2.size(), 32'h0);
        check("queue0_empty", exp_q0.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_latency_responder.md
# ram_latency_responder

Word-granular RAM responder: the memory end of the `ram_req`/`ram_addr`/`ram_we`/`ram_miss` word protocol driven by the cache-to-RAM block glue. It stores `DEPTH` 32-bit words and stalls every access for a configurable number of cycles through `ram_miss`, so that the glue's multi-word block sequencing is exercised under realistic latency. Never-written words read back their own byte address, which keeps the legacy address-echo memory behaviour for existing tests.

## Interface
- `DEPTH`, 16: number of 32-bit words; must be a power of two and at least 2.
- `LATENCY`, 2: `ram_miss` cycles before each word completes; 0 is legal.
- `clock  input  1`: clock.
- `reset  input  1`: reset, asynchronous, active-low.
- `ram_req  input  1`: access request; held high across a whole block burst.
- `ram_addr  input  32`: byte address. Word index is `ram_addr[$clog2(DEPTH)+1:2]`; upper bits alias; `[1:0]` ignored.
- `ram_we  input  1`: 1 = write, 0 = read.
- `ram_write_word  input  32`: write data, sampled in the completion cycle.
- `ram_read_word  output  32`: read data, valid only in a read completion cycle; 0 otherwise.
- `ram_miss  output  1`: 1 = access not yet complete (stall); 0 with `ram_req` = word completes this cycle.
- `protocol_err  output  1`: sticky; set when the requester changes `ram_addr[31:2]` or `ram_we` mid-access.

## Operation
- FSM states:
  - IDLE
    - `ram_req` and `LATENCY` = 0: complete combinationally this cycle and stay in IDLE.
    - `ram_req` and `LATENCY` > 0: latch the address and `we`, load `wait_cnt` = `LATENCY`-1, go to WAIT.
  - WAIT: decrement `wait_cnt`; go to RESP when it is 0.
  - RESP: completion cycle, then go to IDLE.
- `ram_miss` = 1 in IDLE while `ram_req` and `LATENCY` > 0, and in WAIT. It is 0 in RESP, in the `LATENCY` = 0 completion, and whenever `ram_req` is 0.
- Completion uses the latched address and `we` (live inputs when `LATENCY` = 0).
  - Read: `ram_read_word` = stored word if its written bit is set, else `{addr[31:2],2'b00}`.
  - Write: on the clock edge, store `ram_write_word` and set the written bit; `ram_read_word` stays 0.
- Back-to-back: the requester steps to the next address after a completion, and IDLE accepts it on the following cycle. Each word costs `LATENCY`+1 cycles.
- `ram_req` falling in WAIT or RESP aborts the access: return to IDLE, no write, no error.
- In WAIT or RESP, a live address or `we` that differs from the latched one sets `protocol_err`. The access still completes to the latched address. Only reset clears `protocol_err`.

## Timing
- Reset values:
  - state IDLE, `wait_cnt` 0, all written bits 0, `protocol_err` 0, `ram_read_word` 0.
  - `ram_miss` = `ram_req` && (`LATENCY` > 0).
- Read latency: data appears in cycle `LATENCY`+1, counting the request cycle as cycle 1. Data is combinational from the array in that cycle.
- Write commit: at the end of the completion cycle. A read of the same word in a later access returns the new data.
- Reset mid-access: drop immediately to IDLE; a pending write is discarded; all written bits are cleared. Array contents are not reset but read back as unwritten.
- Simultaneous abort and completion: no completion exists in the abort cycle. If `ram_req` is 0 in RESP, no write occurs.

## Structure
- Package `ram_pkg` holds:
  - `WORD_W` = 32.
  - The state enum typedef `ram_state_t` (IDLE/WAIT/RESP).
  - A function mapping a byte address to a word index for a given `DEPTH`.
- Sub-module `ram_word_array` holds the `DEPTH`×32 storage plus the written-bit vector, with an asynchronous clear of the written bits. It has one combinational read port and one synchronous write port.
- The top level holds the FSM, the wait counter, the address/`we` latches and the protocol checker.

## Test plan
- Reset, `LATENCY`=2, read 0x0000_0014 unwritten → `ram_miss` 1,1,0; cycle 3 `ram_read_word`=0x0000_0014; 0 otherwise.
- Write 0xDEADBEEF to 0x08, then read 0x08 → write completes in cycle 3 with `ram_read_word`=0; the read returns 0xDEADBEEF in its cycle 3.
- Glue-style 4-word read burst 0x40–0x4C with `DEPTH`=16 → 12 cycles total, `ram_miss` pattern 110 repeated. Word 0x40 aliases 0x00: write 0x1234 to 0x00 first, and 0x40 returns 0x1234.
- `ram_req` dropped in WAIT of a write 0xCAFE to 0x04 → IDLE, `ram_miss` 0; a later read of 0x04 returns 0x0000_0004.
- Address changed from 0x10 to 0x20 during WAIT → `protocol_err` rises the next cycle and stays 1; the completion reads 0x0000_0010.
- Reset asserted in WAIT of a write, then `LATENCY`=0 build → no write, written bits cleared. With `LATENCY`=0, `ram_miss` stays 0 and each read returns data in the same cycle.
